// File: rtl/ecm_pkg.sv
// Shared types and constants for the ECM stage-1 ladder controllers.
//   state_e   : ladder sequencer states (STATE_W bits wide)
//   kl_width  : derives the k_len width from the maximum scalar width
//   point_t   : projective X/Z point at the default coordinate width
//   ERR_NONE / ERR_KLEN : values reported on the err output
package ecm_pkg;

    localparam int unsigned NUM_WIDTH_DEF = 256;
    localparam int unsigned K_WIDTH_DEF   = 256;

    // k_len must be able to hold K_WIDTH itself, hence the extra bit.
    function automatic int unsigned kl_width(input int unsigned kw);
        return $clog2(kw) + 1;
    endfunction

    localparam int unsigned KL_WIDTH_DEF = kl_width(K_WIDTH_DEF);

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        StIdle,
        StLoad,
        StInitIssue,
        StInitWait,
        StStepIssue,
        StStepWait,
        StDone
    } state_e;

    typedef struct packed {
        logic [NUM_WIDTH_DEF-1:0] x;
        logic [NUM_WIDTH_DEF-1:0] z;
    } point_t;

    localparam logic ERR_NONE = 1'b0;
    localparam logic ERR_KLEN = 1'b1;

endpackage

// File: rtl/ladder_join.sv
// Two-flag rendezvous for a pair of parallel operations.
// Latches each ready pulse while enabled and reports both_done in the cycle the
// second one arrives (or when both arrive together); the flags then clear.
//   clk, rst  : clock, synchronous active-high reset
//   en        : accept ready pulses only while high
//   a_ready   : completion pulse of operation A
//   b_ready   : completion pulse of operation B
//   both_done : both operations have completed (combinational)
module ladder_join (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic a_ready,
    input  logic b_ready,
    output logic both_done
);

    logic a_done_q, a_done_d;
    logic b_done_q, b_done_d;
    logic a_seen, b_seen;

    always_comb begin
        a_seen    = a_done_q | (en & a_ready);
        b_seen    = b_done_q | (en & b_ready);
        both_done = en & a_seen & b_seen;
        a_done_d  = a_done_q;
        b_done_d  = b_done_q;
        if (en) begin
            a_done_d = a_seen & ~both_done;
            b_done_d = b_seen & ~both_done;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_done_q <= 1'b0;
            b_done_q <= 1'b0;
        end else begin
            a_done_q <= a_done_d;
            b_done_q <= b_done_d;
        end
    end

endmodule

// File: rtl/ladder_ctrl.sv
// Montgomery-ladder sequencer: computes X/Z of k*P using one external
// differential-add unit and one external doubling unit.
//   clk, rst            : clock, synchronous active-high reset
//   start / busy / ready: request, in-progress flag, one-cycle result pulse
//   err                 : k_len was 0 or larger than K_WIDTH (valid with ready)
//   X_P, Z_P, k, k_len  : base point, scalar and its significant bit count
//   X_out, Z_out        : result, held until the next result
//   add_* / dbl_*       : start/ready handshake and operands/results of the units
// Optional build macro LADDER_PERF_CNT_EN adds cycle_cnt (LOAD..DONE cycles,
// saturating) and step_cnt (ladder steps completed).
module ladder_ctrl
    import ecm_pkg::*;
#(
    parameter int unsigned NUM_WIDTH = 256,
    parameter int unsigned K_WIDTH   = 256,
    parameter int unsigned KL_WIDTH  = kl_width(K_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 ready,
    output logic                 err,
    input  logic [NUM_WIDTH-1:0] X_P,
    input  logic [NUM_WIDTH-1:0] Z_P,
    input  logic [K_WIDTH-1:0]   k,
    input  logic [KL_WIDTH-1:0]  k_len,
    output logic [NUM_WIDTH-1:0] X_out,
    output logic [NUM_WIDTH-1:0] Z_out,
    output logic                 add_start,
    input  logic                 add_ready,
    output logic [NUM_WIDTH-1:0] add_XP,
    output logic [NUM_WIDTH-1:0] add_ZP,
    output logic [NUM_WIDTH-1:0] add_XQ,
    output logic [NUM_WIDTH-1:0] add_ZQ,
    output logic [NUM_WIDTH-1:0] add_Xd,
    output logic [NUM_WIDTH-1:0] add_Zd,
    input  logic [NUM_WIDTH-1:0] add_X,
    input  logic [NUM_WIDTH-1:0] add_Z,
    output logic                 dbl_start,
    input  logic                 dbl_ready,
    output logic [NUM_WIDTH-1:0] dbl_X,
    output logic [NUM_WIDTH-1:0] dbl_Z,
    input  logic [NUM_WIDTH-1:0] dbl_Xr,
    input  logic [NUM_WIDTH-1:0] dbl_Zr
`ifdef LADDER_PERF_CNT_EN
    ,
    output logic [31:0]          cycle_cnt,
    output logic [KL_WIDTH-1:0]  step_cnt
`endif
);

    localparam int unsigned IDX_W = (K_WIDTH > 1) ? $clog2(K_WIDTH) : 1;

    state_e               state_q, state_d;
    logic [K_WIDTH-1:0]   k_q, k_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [NUM_WIDTH-1:0] p_x_q, p_x_d, p_z_q, p_z_d;
    logic [NUM_WIDTH-1:0] r0_x_q, r0_x_d, r0_z_q, r0_z_d;
    logic [NUM_WIDTH-1:0] r1_x_q, r1_x_d, r1_z_q, r1_z_d;
    logic [NUM_WIDTH-1:0] add_hx_q, add_hx_d, add_hz_q, add_hz_d;
    logic [NUM_WIDTH-1:0] dbl_hx_q, dbl_hx_d, dbl_hz_q, dbl_hz_d;
    logic [NUM_WIDTH-1:0] x_out_q, x_out_d, z_out_q, z_out_d;
    logic                 err_flag_q, err_flag_d;
    logic                 err_out_q, err_out_d;
    logic                 ready_q, ready_d;
    logic                 cur_bit, klen_bad, both_done, step_wait;
    logic [NUM_WIDTH-1:0] add_vx, add_vz, dbl_vx, dbl_vz;

    assign cur_bit   = k_q[idx_q];
    assign klen_bad  = (k_len == '0) || (k_len > KL_WIDTH'(K_WIDTH));
    assign step_wait = (state_q == StStepWait);

    ladder_join u_join (
        .clk       (clk),
        .rst       (rst),
        .en        (step_wait),
        .a_ready   (add_ready),
        .b_ready   (dbl_ready),
        .both_done (both_done)
    );

    // A result arriving in the rendezvous cycle is used directly, else the held copy.
    assign add_vx = add_ready ? add_X : add_hx_q;
    assign add_vz = add_ready ? add_Z : add_hz_q;
    assign dbl_vx = dbl_ready ? dbl_Xr : dbl_hx_q;
    assign dbl_vz = dbl_ready ? dbl_Zr : dbl_hz_q;

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        idx_d      = idx_q;
        p_x_d      = p_x_q;
        p_z_d      = p_z_q;
        r0_x_d     = r0_x_q;
        r0_z_d     = r0_z_q;
        r1_x_d     = r1_x_q;
        r1_z_d     = r1_z_q;
        add_hx_d   = add_hx_q;
        add_hz_d   = add_hz_q;
        dbl_hx_d   = dbl_hx_q;
        dbl_hz_d   = dbl_hz_q;
        x_out_d    = x_out_q;
        z_out_d    = z_out_q;
        err_flag_d = err_flag_q;
        err_out_d  = err_out_q;
        ready_d    = 1'b0;

        if (step_wait && add_ready) begin
            add_hx_d = add_X;
            add_hz_d = add_Z;
        end
        if (step_wait && dbl_ready) begin
            dbl_hx_d = dbl_Xr;
            dbl_hz_d = dbl_Zr;
        end

        unique case (state_q)
            StIdle: begin
                if (start) state_d = StLoad;
            end
            StLoad: begin
                k_d   = k;
                p_x_d = X_P;
                p_z_d = Z_P;
                if (klen_bad) begin
                    err_flag_d = ERR_KLEN;
                    r0_x_d     = '0;
                    r0_z_d     = '0;
                    state_d    = StDone;
                end else begin
                    err_flag_d = ERR_NONE;
                    r0_x_d     = X_P;
                    r0_z_d     = Z_P;
                    if (k_len == KL_WIDTH'(1)) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = IDX_W'(k_len - KL_WIDTH'(2));
                        state_d = StInitIssue;
                    end
                end
            end
            StInitIssue: state_d = StInitWait;
            StInitWait: begin
                if (dbl_ready) begin
                    r1_x_d  = dbl_Xr;
                    r1_z_d  = dbl_Zr;
                    state_d = StStepIssue;
                end
            end
            StStepIssue: state_d = StStepWait;
            StStepWait: begin
                if (both_done) begin
                    if (cur_bit) begin
                        r0_x_d = add_vx;
                        r0_z_d = add_vz;
                        r1_x_d = dbl_vx;
                        r1_z_d = dbl_vz;
                    end else begin
                        r1_x_d = add_vx;
                        r1_z_d = add_vz;
                        r0_x_d = dbl_vx;
                        r0_z_d = dbl_vz;
                    end
                    if (idx_q == '0) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q - IDX_W'(1);
                        state_d = StStepIssue;
                    end
                end
            end
            StDone: begin
                x_out_d   = r0_x_q;
                z_out_d   = r0_z_q;
                err_out_d = err_flag_q;
                ready_d   = 1'b1;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            k_q        <= '0;
            idx_q      <= '0;
            p_x_q      <= '0;
            p_z_q      <= '0;
            r0_x_q     <= '0;
            r0_z_q     <= '0;
            r1_x_q     <= '0;
            r1_z_q     <= '0;
            add_hx_q   <= '0;
            add_hz_q   <= '0;
            dbl_hx_q   <= '0;
            dbl_hz_q   <= '0;
            x_out_q    <= '0;
            z_out_q    <= '0;
            err_flag_q <= ERR_NONE;
            err_out_q  <= ERR_NONE;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            idx_q      <= idx_d;
            p_x_q      <= p_x_d;
            p_z_q      <= p_z_d;
            r0_x_q     <= r0_x_d;
            r0_z_q     <= r0_z_d;
            r1_x_q     <= r1_x_d;
            r1_z_q     <= r1_z_d;
            add_hx_q   <= add_hx_d;
            add_hz_q   <= add_hz_d;
            dbl_hx_q   <= dbl_hx_d;
            dbl_hz_q   <= dbl_hz_d;
            x_out_q    <= x_out_d;
            z_out_q    <= z_out_d;
            err_flag_q <= err_flag_d;
            err_out_q  <= err_out_d;
            ready_q    <= ready_d;
        end
    end

    // Operands are pure functions of registers that only change after the
    // matching ready, so they stay stable for the whole operation.
    logic init_phase;
    assign init_phase = (state_q == StInitIssue) || (state_q == StInitWait);

    assign busy      = (state_q != StIdle);
    assign ready     = ready_q;
    assign err       = err_out_q;
    assign X_out     = x_out_q;
    assign Z_out     = z_out_q;
    assign add_start = (state_q == StStepIssue);
    assign dbl_start = (state_q == StStepIssue) || (state_q == StInitIssue);
    assign add_XP    = r0_x_q;
    assign add_ZP    = r0_z_q;
    assign add_XQ    = r1_x_q;
    assign add_ZQ    = r1_z_q;
    assign add_Xd    = p_x_q;
    assign add_Zd    = p_z_q;
    assign dbl_X     = init_phase ? p_x_q : (cur_bit ? r1_x_q : r0_x_q);
    assign dbl_Z     = init_phase ? p_z_q : (cur_bit ? r1_z_q : r0_z_q);

`ifdef LADDER_PERF_CNT_EN
    logic [31:0]         run_cnt_q;
    logic [31:0]         cycle_cnt_q;
    logic [KL_WIDTH-1:0] step_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            run_cnt_q   <= '0;
            cycle_cnt_q <= '0;
            step_cnt_q  <= '0;
        end else begin
            if (state_q == StLoad) begin
                run_cnt_q  <= 32'd1;
                step_cnt_q <= '0;
            end else if (state_q != StIdle && run_cnt_q != '1) begin
                run_cnt_q <= run_cnt_q + 32'd1;
            end
            if (both_done) step_cnt_q <= step_cnt_q + KL_WIDTH'(1);
            // run_cnt_q has counted up to the cycle before DONE; add DONE itself.
            if (state_q == StDone) begin
                cycle_cnt_q <= (run_cnt_q == '1) ? run_cnt_q : run_cnt_q + 32'd1;
            end
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign step_cnt  = step_cnt_q;
`else
    // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_ladder_ctrl.sv
// Self-checking bench for ladder_ctrl with stub add (P+Q) and dbl (2P) units,
// so the ladder result is simply k times the base point.
module tb_ladder_ctrl;

    localparam int unsigned NW  = 256;
    localparam int unsigned KW  = 256;
    localparam int unsigned KLW = 9;

    logic          clk = 1'b0;
    logic          rst, start, busy, ready, err;
    logic [NW-1:0] X_P, Z_P, X_out, Z_out;
    logic [KW-1:0] k;
    logic [KLW-1:0] k_len;
    logic          add_start, add_ready, dbl_start, dbl_ready;
    logic [NW-1:0] add_XP, add_ZP, add_XQ, add_ZQ, add_Xd, add_Zd, add_X, add_Z;
    logic [NW-1:0] dbl_X, dbl_Z, dbl_Xr, dbl_Zr;
`ifdef LADDER_PERF_CNT_EN
    logic [31:0]    cycle_cnt;
    logic [KLW-1:0] step_cnt;
`endif

    always #5 clk = ~clk;

    ladder_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .ready     (ready),
        .err       (err),
        .X_P       (X_P),
        .Z_P       (Z_P),
        .k         (k),
        .k_len     (k_len),
        .X_out     (X_out),
        .Z_out     (Z_out),
        .add_start (add_start),
        .add_ready (add_ready),
        .add_XP    (add_XP),
        .add_ZP    (add_ZP),
        .add_XQ    (add_XQ),
        .add_ZQ    (add_ZQ),
        .add_Xd    (add_Xd),
        .add_Zd    (add_Zd),
        .add_X     (add_X),
        .add_Z     (add_Z),
        .dbl_start (dbl_start),
        .dbl_ready (dbl_ready),
        .dbl_X     (dbl_X),
        .dbl_Z     (dbl_Z),
        .dbl_Xr    (dbl_Xr),
        .dbl_Zr    (dbl_Zr)
`ifdef LADDER_PERF_CNT_EN
        ,
        .cycle_cnt (cycle_cnt),
        .step_cnt  (step_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;
    int add_lat = 3;
    int dbl_lat = 3;
    logic [NW-1:0] base_x, base_z;

    typedef struct {
        logic [NW-1:0] x;
        logic [NW-1:0] z;
        logic          err;
        int            adds;
        int            dbls;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [NW-1:0] act, input logic [NW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [NW-1:0] x, input logic [NW-1:0] z,
                                input logic e, input int adds, input int dbls);
        exp_t r;
        r.x = x; r.z = z; r.err = e; r.adds = adds; r.dbls = dbls;
        return r;
    endfunction

    // Stub units: operands sampled one cycle after start, ready after *_lat cycles.
    logic a_busy = 1'b0, d_busy = 1'b0;
    int a_cnt = 0, d_cnt = 0;
    logic [NW-1:0] a_rx, a_rz, d_rx, d_rz;

    always @(posedge clk) begin
        add_ready <= 1'b0;
        dbl_ready <= 1'b0;
        if (rst) begin
            a_busy = 1'b0;
            d_busy = 1'b0;
        end else begin
            if (add_start || dbl_start) chk("no_start_while_outstanding", NW'(a_busy || d_busy), '0);
            if (a_busy) begin
                a_cnt++;
                if (a_cnt == 1) begin
                    a_rx = add_XP + add_XQ;
                    a_rz = add_ZP + add_ZQ;
                    chk("add_diff_x", add_Xd, base_x);
                    chk("add_diff_z", add_Zd, base_z);
                end
                if (a_cnt >= add_lat) begin
                    add_X     <= a_rx;
                    add_Z     <= a_rz;
                    add_ready <= 1'b1;
                    a_busy = 1'b0;
                end
            end
            if (d_busy) begin
                d_cnt++;
                if (d_cnt == 1) begin
                    d_rx = dbl_X + dbl_X;
                    d_rz = dbl_Z + dbl_Z;
                end
                if (d_cnt >= dbl_lat) begin
                    dbl_Xr    <= d_rx;
                    dbl_Zr    <= d_rz;
                    dbl_ready <= 1'b1;
                    d_busy = 1'b0;
                end
            end
            if (add_start) begin a_busy = 1'b1; a_cnt = 0; end
            if (dbl_start) begin d_busy = 1'b1; d_cnt = 0; end
        end
    end

    // Monitor: counts unit starts per operation and checks each ready against the queue.
    int n_add = 0, n_dbl = 0;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst) begin
            n_add = 0;
            n_dbl = 0;
        end else begin
            if (add_start) n_add++;
            if (dbl_start) n_dbl++;
            if (ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_ready: got ready=1, expected no pending operation");
                end else begin
                    e = sb.pop_front();
                    chk("X_out", X_out, e.x);
                    chk("Z_out", Z_out, e.z);
                    chk("err", NW'(err), NW'(e.err));
                    chk("add_start_count", NW'(n_add), NW'(e.adds));
                    chk("dbl_start_count", NW'(n_dbl), NW'(e.dbls));
                end
                n_add = 0;
                n_dbl = 0;
            end
        end
    end

    // Issue one request; inputs are scrambled once LOAD has registered them.
    task automatic launch(input logic [NW-1:0] x, input logic [NW-1:0] z,
                          input logic [KW-1:0] kk, input logic [KLW-1:0] kl, input exp_t e);
        @(negedge clk);
        X_P = x; Z_P = z; k = kk; k_len = kl;
        base_x = x; base_z = z;
        start = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        X_P = ~x; Z_P = ~z; k = ~kk; k_len = kl + KLW'(3);
    endtask

    // Wait for ready; lat counts negedges from the start negedge.
    task automatic wait_ready(output int lat);
        lat = 2;
        do begin
            @(negedge clk);
            lat++;
        end while (!ready && lat < 5000);
        if (!ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got no ready after %0d cycles, expected ready", lat);
            sb.delete();
        end
    endtask

    task automatic run_op(input logic [NW-1:0] x, input logic [NW-1:0] z,
                          input logic [KW-1:0] kk, input logic [KLW-1:0] kl, input exp_t e,
                          output int lat);
        launch(x, z, kk, kl, e);
        wait_ready(lat);
    endtask

    initial begin
        int lat;
        int budget;
        logic [KW-1:0] big_k;
        rst = 1'b1; start = 1'b0; X_P = '0; Z_P = '0; k = '0; k_len = '0;
        add_X = '0; add_Z = '0; dbl_Xr = '0; dbl_Zr = '0;
        base_x = '0; base_z = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", NW'(busy), '0);
        chk("reset_ready", NW'(ready), '0);
        chk("reset_err", NW'(err), '0);
        chk("reset_X_out", X_out, '0);
        chk("reset_Z_out", Z_out, '0);
        chk("reset_add_start", NW'(add_start), '0);
        chk("reset_dbl_start", NW'(dbl_start), '0);
        chk("reset_add_XP", add_XP, '0);
        chk("reset_dbl_X", dbl_X, '0);
        rst = 1'b0;

        // 11*P with k=1011.
        run_op(256'd3, 256'd1, 256'b1011, 9'd4, mk(256'd33, 256'd11, 1'b0, 3, 4), lat);
        // Bits above L-1 ignored and bit L-1 forced to 1: 0xF3, L=4 acts as 1011.
        run_op(256'd2, 256'd1, 256'hF3, 9'd4, mk(256'd22, 256'd11, 1'b0, 3, 4), lat);
        // k_len=1 returns P with no unit activity, ready three cycles after start.
        run_op(256'd5, 256'd9, 256'd1, 9'd1, mk(256'd5, 256'd9, 1'b0, 0, 0), lat);
        chk("klen1_latency", NW'(lat), NW'(3));
        // Invalid lengths.
        run_op(256'd5, 256'd9, 256'd5, 9'd0, mk('0, '0, 1'b1, 0, 0), lat);
        run_op(256'd5, 256'd9, 256'd5, 9'd257, mk('0, '0, 1'b1, 0, 0), lat);

        // Latency mixes with k=0xFF, L=8.
        add_lat = 5; dbl_lat = 20;
        run_op(256'd3, 256'd1, 256'hFF, 9'd8, mk(256'd765, 256'd255, 1'b0, 7, 8), lat);
        add_lat = 20; dbl_lat = 5;
        run_op(256'd7, 256'd2, 256'hFF, 9'd8, mk(256'd1785, 256'd510, 1'b0, 7, 8), lat);
        add_lat = 4; dbl_lat = 4;
        run_op(256'd1, 256'd4, 256'hFF, 9'd8, mk(256'd255, 256'd1020, 1'b0, 7, 8), lat);

        // Full-width scalar: P=(1,2) gives (k, 2k mod 2^256).
        add_lat = 2; dbl_lat = 3;
        big_k = {4{64'hDEADBEEF_01234567}};
        run_op(256'd1, 256'd2, big_k, 9'd256, mk(big_k, big_k + big_k, 1'b0, 255, 256), lat);

        // Reset during STEP_WAIT.
        add_lat = 5; dbl_lat = 20;
        launch(256'd3, 256'd1, 256'hFF, 9'd8, mk('0, '0, 1'b0, 0, 0));
        budget = 0;
        while (n_dbl < 2 && budget < 500) begin
            @(negedge clk);
            budget++;
        end
        chk("reach_step_wait", NW'(n_dbl >= 2), NW'(1));
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sb.delete();
        chk("midreset_busy", NW'(busy), '0);
        chk("midreset_ready", NW'(ready), '0);
        chk("midreset_X_out", X_out, '0);

        // Rerun with a second start while busy that must be ignored.
        add_lat = 3; dbl_lat = 6;
        launch(256'd4, 256'd3, 256'd6, 9'd3, mk(256'd24, 256'd18, 1'b0, 2, 3));
        repeat (2) @(negedge clk);
        chk("busy_during_op", NW'(busy), NW'(1));
        k = 256'd7; k_len = 9'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_ready(lat);
        repeat (40) @(negedge clk);
        chk("scoreboard_empty", NW'(sb.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
